// File: rtl/rf80386_pkg.sv
// Shared opcode constants, FSM state type and small decode helpers for the
// 80386 short-branch execution unit.
package rf80386_pkg;

  localparam logic [7:0] OP_JCC_BASE = 8'h70;
  localparam logic [7:0] OP_LOOPNZ   = 8'hE0;
  localparam logic [7:0] OP_LOOPZ    = 8'hE1;
  localparam logic [7:0] OP_LOOP     = 8'hE2;
  localparam logic [7:0] OP_JCXZ     = 8'hE3;
  localparam logic [7:0] OP_JMPS     = 8'hEB;

  typedef enum logic [1:0] {IDLE, EVAL, REDIR, DONE} br_state_e;

  // 0F 8x Jcc shares its condition nibble with the short 7x form.
  function automatic logic [7:0] eff_opcode(input logic near, input logic [7:0] ir);
    return near ? {OP_JCC_BASE[7:4], ir[3:0]} : ir;
  endfunction

  function automatic logic is_jcc(input logic [7:0] op);
    return op[7:4] == OP_JCC_BASE[7:4];
  endfunction

  function automatic logic is_loop(input logic [7:0] op);
    return (op == OP_LOOPNZ) || (op == OP_LOOPZ) || (op == OP_LOOP);
  endfunction

  function automatic logic is_known(input logic [7:0] op);
    return is_jcc(op) || is_loop(op) || (op == OP_JCXZ) || (op == OP_JMPS);
  endfunction

  // With 16-bit size only CX counts; the upper half of ECX is preserved.
  function automatic logic [31:0] dec_count(input logic big, input logic [31:0] ecx);
    return big ? (ecx - 32'd1) : {ecx[31:16], ecx[15:0] - 16'd1};
  endfunction

endpackage

// File: rtl/evaluate_branch.sv
// Combinational branch condition: Jcc flag tests, JMPS, the LOOP family and
// JCXZ, all judged on pre-decrement count and flags.
module evaluate_branch
  import rf80386_pkg::*;
(
  input  logic        big_i,
  input  logic [7:0]  ir_i,
  input  logic [31:0] ecx_i,
  input  logic        zf_i,
  input  logic        cf_i,
  input  logic        sf_i,
  input  logic        vf_i,
  input  logic        pf_i,
  output logic        take_br_o
);

  logic [31:0] cnt;
  logic        cnt_zero;
  logic        cnt_one;
  logic        cc;

  assign cnt      = big_i ? ecx_i : {16'h0000, ecx_i[15:0]};
  assign cnt_zero = (cnt == 32'd0);
  // LOOPx continues when count-1 is nonzero, i.e. the old count is not one.
  assign cnt_one  = (cnt == 32'd1);

  always_comb begin
    case (ir_i[3:1])
      3'd0:    cc = vf_i;
      3'd1:    cc = cf_i;
      3'd2:    cc = zf_i;
      3'd3:    cc = cf_i | zf_i;
      3'd4:    cc = sf_i;
      3'd5:    cc = pf_i;
      3'd6:    cc = sf_i ^ vf_i;
      default: cc = zf_i | (sf_i ^ vf_i);
    endcase
  end

  always_comb begin
    take_br_o = 1'b0;
    if (is_jcc(ir_i)) begin
      take_br_o = cc ^ ir_i[0];
    end else begin
      case (ir_i)
        OP_JMPS:   take_br_o = 1'b1;
        OP_LOOPNZ: take_br_o = ~cnt_one & ~zf_i;
        OP_LOOPZ:  take_br_o = ~cnt_one & zf_i;
        OP_LOOP:   take_br_o = ~cnt_one;
        OP_JCXZ:   take_br_o = cnt_zero;
        default:   take_br_o = 1'b0;
      endcase
    end
  end

endmodule

// File: rtl/branch_exec.sv
// Branch execution unit: accepts one branch op, updates ECX for LOOPx,
// issues a fetch redirect when taken and reports completion.
module branch_exec
  import rf80386_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        big_i,
  input  logic [7:0]  ir_i,
  input  logic        near_i,
  input  logic [31:0] disp_i,
  input  logic [31:0] eip_i,
  input  logic [31:0] ecx_i,
  input  logic        zf_i,
  input  logic        cf_i,
  input  logic        sf_i,
  input  logic        vf_i,
  input  logic        pf_i,
  output logic        ecx_we_o,
  output logic [31:0] ecx_o,
  output logic        redir_valid_o,
  output logic [31:0] redir_eip_o,
  input  logic        redir_ready_i,
  output logic        done_o,
  output logic        taken_o,
  output logic        bad_op_o,
  input  logic        flush_i
);

  br_state_e   state_q;
  logic        ready_q;
  logic        big_q, near_q;
  logic        zf_q, cf_q, sf_q, vf_q, pf_q;
  logic [7:0]  ir_q;
  logic [31:0] disp_q, eip_q, ecx_q;
  logic        ecx_we_q, redir_valid_q, done_q, taken_q, bad_op_q;
  logic [31:0] redir_eip_q;

  logic [7:0]  op_eff;
  logic        take_br;
  logic [31:0] sum;
  logic [31:0] target;

  assign op_eff = eff_opcode(near_q, ir_q);
  assign sum    = eip_q + disp_q;
  assign target = big_q ? sum : {16'h0000, sum[15:0]};

  evaluate_branch u_eval (
    .big_i     (big_q),
    .ir_i      (op_eff),
    .ecx_i     (ecx_q),
    .zf_i      (zf_q),
    .cf_i      (cf_q),
    .sf_i      (sf_q),
    .vf_i      (vf_q),
    .pf_i      (pf_q),
    .take_br_o (take_br)
  );

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q       <= IDLE;
      ready_q       <= 1'b0;
      big_q         <= 1'b0;
      near_q        <= 1'b0;
      ir_q          <= '0;
      disp_q        <= '0;
      eip_q         <= '0;
      ecx_q         <= '0;
      zf_q          <= 1'b0;
      cf_q          <= 1'b0;
      sf_q          <= 1'b0;
      vf_q          <= 1'b0;
      pf_q          <= 1'b0;
      ecx_we_q      <= 1'b0;
      redir_valid_q <= 1'b0;
      redir_eip_q   <= '0;
      done_q        <= 1'b0;
      taken_q       <= 1'b0;
      bad_op_q      <= 1'b0;
    end else if (flush_i) begin
      state_q       <= IDLE;
      ready_q       <= 1'b1;
      ecx_we_q      <= 1'b0;
      redir_valid_q <= 1'b0;
      done_q        <= 1'b0;
      taken_q       <= 1'b0;
      bad_op_q      <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (req_valid_i && ready_q) begin
            big_q    <= big_i;
            near_q   <= near_i;
            ir_q     <= ir_i;
            disp_q   <= disp_i;
            eip_q    <= eip_i;
            ecx_q    <= ecx_i;
            zf_q     <= zf_i;
            cf_q     <= cf_i;
            sf_q     <= sf_i;
            vf_q     <= vf_i;
            pf_q     <= pf_i;
            // Registered here so the write strobe lines up with the EVAL cycle.
            ecx_we_q <= is_loop(eff_opcode(near_i, ir_i));
            ready_q  <= 1'b0;
            state_q  <= EVAL;
          end else begin
            ready_q <= 1'b1;
          end
        end
        EVAL: begin
          ecx_we_q <= 1'b0;
          if (take_br) begin
            redir_valid_q <= 1'b1;
            redir_eip_q   <= target;
            state_q       <= REDIR;
          end else begin
            done_q   <= 1'b1;
            bad_op_q <= ~is_known(op_eff);
            state_q  <= DONE;
          end
        end
        REDIR: begin
          if (redir_ready_i) begin
            redir_valid_q <= 1'b0;
            done_q        <= 1'b1;
            taken_q       <= 1'b1;
            state_q       <= DONE;
          end
        end
        default: begin
          done_q   <= 1'b0;
          taken_q  <= 1'b0;
          bad_op_q <= 1'b0;
          ready_q  <= 1'b1;
          state_q  <= IDLE;
        end
      endcase
    end
  end

  assign req_ready_o   = ready_q & ~flush_i;
  assign ecx_we_o      = ecx_we_q;
  assign ecx_o         = ecx_we_q ? dec_count(big_q, ecx_q) : '0;
  assign redir_valid_o = redir_valid_q;
  assign redir_eip_o   = redir_eip_q;
  assign done_o        = done_q;
  assign taken_o       = taken_q;
  assign bad_op_o      = bad_op_q;

endmodule

// File: doc/branch_exec.md
BRANCH_EXEC -- requirements
Module: branch_exec

Interface
REQ-001 SHALL have port clk_i, input, 1: sole clock, all state on rising edge.
REQ-002 SHALL have port rst_ni, input, 1: reset, asynchronous, active-low.
REQ-003 SHALL have port req_valid_i, input, 1: branch op offered; req_ready_o, output, 1: op accepted when both high.
REQ-004 SHALL have port big_i, input, 1: 32-bit operand/address size (0 = 16-bit).
REQ-005 SHALL have port ir_i, input, 8: opcode; near_i, input, 1: 0F-prefixed Jcc (condition = ir_i[3:0]).
REQ-006 SHALL have port disp_i, input, 32: displacement, pre-sign-extended by decoder.
REQ-007 SHALL have port eip_i, input, 32: address of next sequential instruction.
REQ-008 SHALL have port ecx_i, input, 32: current ECX; ports zf_i, cf_i, sf_i, vf_i, pf_i, input, 1 each: flags.
REQ-009 SHALL have port ecx_we_o, output, 1, and ecx_o, output, 32: ECX writeback.
REQ-010 SHALL have port redir_valid_o, output, 1; redir_eip_o, output, 32; redir_ready_i, input, 1: fetch redirect handshake.
REQ-011 SHALL have port done_o, output, 1; taken_o, output, 1; bad_op_o, output, 1: completion report.
REQ-012 SHALL have port flush_i, input, 1: pipeline abort.

Function
REQ-013 SHALL implement FSM states IDLE, EVAL, REDIR, DONE; req_ready_o = 1 only in IDLE.
REQ-014 IDLE: on req_valid_i, SHALL latch all request inputs and go to EVAL.
REQ-015 EVAL: effective opcode = near_i ? {4'h7, ir[3:0]} : ir; SHALL evaluate condition with latched ECX/flags (pre-decrement values for LOOP family).
REQ-016 EVAL: for LOOP/LOOPZ/LOOPNZ (E2/E1/E0) SHALL pulse ecx_we_o one cycle with ecx_o = ECX-1; when big=0 only [15:0] decremented mod 2^16, [31:16] preserved; JCXZ SHALL not write ECX.
REQ-017 Target = eip + disp mod 2^32; when big=0 SHALL zero target[31:16] after 16-bit add (wrap FFFF->0000).
REQ-018 EVAL: taken -> REDIR; not taken -> DONE.
REQ-019 REDIR: redir_valid_o held with stable redir_eip_o until redir_ready_i sampled high, then DONE.
REQ-020 DONE: done_o pulses one cycle with taken_o valid, then IDLE; taken_o/bad_op_o are 0 outside DONE.
REQ-021 Opcode outside {EB, 70-7F, E0-E3, near Jcc}: not taken, no ECX write, bad_op_o = 1 in DONE.
REQ-022 Latency from accept: not-taken done_o at +2 cycles; taken with ready high redirect at +2, done_o at +3.
REQ-023 flush_i SHALL force IDLE next cycle from any state, suppressing pending redirect/done; flush wins over simultaneous redir_ready_i; an ecx_we_o already pulsed is not undone; flush in IDLE blocks acceptance that cycle.
REQ-024 ecx_we_o, redir_valid_o, done_o SHALL never be high in the same cycle.

Reset
REQ-025 On rst_ni low: state IDLE, all outputs 0 (req_ready_o 1 after release), latched registers 0; reset mid-REDIR drops redirect.

Structure
REQ-026 Opcode constants (JMPS, Jcc, LOOPx, JCXZ) and state enum SHALL live in shared package rf80386_pkg.
REQ-027 Condition logic SHALL be sub-module evaluate_branch (big, ir, ecx, zf, cf, sf, vf, pf -> take_br), instantiated once.

Verification
REQ-028 JNE (75), zf=0, eip=0000_1000, disp=FFFF_FFF0, big=1 -> redir_eip 0000_0FF0, taken_o=1.
REQ-029 LOOP (E2), big=0, ecx=ABCD_0000 -> ecx_o ABCD_FFFF, taken; ecx=0000_0001 -> ecx_o 0, not taken, done at +2.
REQ-030 JMPS (EB), big=0, eip=0000_FFF0, disp=0000_0020 -> redir_eip 0000_0010.
REQ-031 near_i=1, ir=8C (JL), sf=1, vf=0 -> taken; redir_ready_i low 5 cycles -> redir_valid_o/eip stable throughout.
REQ-032 flush_i asserted in REDIR together with redir_ready_i -> no done_o, IDLE next cycle, req_ready_o=1.
REQ-033 ir=90 -> bad_op_o=1, taken_o=0, ecx_we_o never asserted.
